// File: rtl/rc4_pkg.sv
// Shared types and default widths for the RC4 key-scheduling shuffler.
// RC4_INIT_PHASE_EN adds the INIT state that fills s[n]=n before shuffling.
package rc4_pkg;

  localparam int unsigned RC4_DATA_W        = 8;
  localparam int unsigned RC4_ADDR_W        = 8;
  localparam int unsigned RC4_MAX_KEY_BYTES = 32;
  localparam int unsigned RC4_RD_LAT        = 1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef RC4_INIT_PHASE_EN
    INIT,
`endif
    ISSUE_I,
    WAIT_I,
    ISSUE_J,
    WAIT_J,
    WR_I,
    WR_J
  } ksa_state_t;

endpackage

// File: rtl/ksa_shuffler_if.sv
// RAM port bundle between the shuffler (master) and the state RAM (slave).
interface ksa_shuffler_if #(
  parameter int unsigned DATA_W = rc4_pkg::RC4_DATA_W,
  parameter int unsigned ADDR_W = rc4_pkg::RC4_ADDR_W
) ();

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] ram_in;
  logic              write_enable;
  logic [DATA_W-1:0] ram_out;

  modport master (output address, output ram_in, output write_enable, input ram_out);
  modport slave  (input address, input ram_in, input write_enable, output ram_out);

endinterface

// File: rtl/rc4_key_sched.sv
// Latched key, effective key length and wrapping key-index counter (i mod len without a divider).
module rc4_key_sched
  import rc4_pkg::*;
#(
  parameter int unsigned DATA_W        = RC4_DATA_W,
  parameter int unsigned MAX_KEY_BYTES = RC4_MAX_KEY_BYTES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                advance,
  input  logic [MAX_KEY_BYTES*DATA_W-1:0]     key,
  input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]  key_len,
  output logic [DATA_W-1:0]                   key_byte
);

  localparam int unsigned LEN_W = $clog2(MAX_KEY_BYTES + 1);
  localparam int unsigned NSLOT = 1 << LEN_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_KEY_BYTES);

  logic [MAX_KEY_BYTES*DATA_W-1:0] key_q;
  logic [LEN_W-1:0]                len_q;
  logic [LEN_W-1:0]                idx_q;
  logic [LEN_W-1:0]                len_eff;
  logic [DATA_W-1:0]               slot [NSLOT];

  // Byte 0 is the most significant byte; slots past the key capacity read as zero.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < MAX_KEY_BYTES) begin : g_key
      assign slot[g] = key_q[(MAX_KEY_BYTES-1-g)*DATA_W +: DATA_W];
    end else begin : g_pad
      assign slot[g] = '0;
    end
  end

  assign key_byte = slot[idx_q];
  assign len_eff  = ((key_len == '0) || (key_len > MAX_LEN)) ? MAX_LEN : key_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      key_q <= key;
      len_q <= len_eff;
      idx_q <= '0;
    end else if (advance) begin
      idx_q <= (LEN_W'(idx_q + 1'b1) == len_q) ? '0 : LEN_W'(idx_q + 1'b1);
    end
  end

endmodule

// File: rtl/ksa_shuffler.sv
// RC4 key-scheduling shuffle over an external RAM with RD_LAT-cycle reads.
// Define RC4_INIT_PHASE_EN to fill s[n]=n in an INIT phase before shuffling.
module ksa_shuffler
  import rc4_pkg::*;
#(
  parameter int unsigned DATA_W        = RC4_DATA_W,
  parameter int unsigned ADDR_W        = RC4_ADDR_W,
  parameter int unsigned MAX_KEY_BYTES = RC4_MAX_KEY_BYTES,
  parameter int unsigned RD_LAT        = RC4_RD_LAT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [MAX_KEY_BYTES*DATA_W-1:0]     key,
  input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]  key_len,
  output logic                                busy,
  output logic                                done,
  ksa_shuffler_if.master                      ram
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  ksa_state_t        state, state_nxt;
  logic [ADDR_W-1:0] i, i_nxt, j, j_nxt, j_sum, addr_q, addr_nxt;
  logic [DATA_W-1:0] si, si_nxt, sj, sj_nxt, din_q, din_nxt, key_byte;
  logic [1:0]        wait_cnt, wait_nxt;
  logic              we_q, we_nxt, done_nxt, busy_nxt, key_load, key_adv;
`ifdef RC4_INIT_PHASE_EN
  logic [ADDR_W-1:0] init_cnt, init_nxt;
`endif

  assign ram.address      = addr_q;
  assign ram.ram_in       = din_q;
  assign ram.write_enable = we_q;

  rc4_key_sched #(
    .DATA_W        (DATA_W),
    .MAX_KEY_BYTES (MAX_KEY_BYTES)
  ) u_key_sched (
    .clk      (clk),
    .reset    (reset),
    .load     (key_load),
    .advance  (key_adv),
    .key      (key),
    .key_len  (key_len),
    .key_byte (key_byte)
  );

  assign j_sum = j + ADDR_W'(ram.ram_out) + ADDR_W'(key_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      wait_cnt <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef RC4_INIT_PHASE_EN
      init_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      i        <= i_nxt;
      j        <= j_nxt;
      si       <= si_nxt;
      sj       <= sj_nxt;
      wait_cnt <= wait_nxt;
      addr_q   <= addr_nxt;
      din_q    <= din_nxt;
      we_q     <= we_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
`ifdef RC4_INIT_PHASE_EN
      init_cnt <= init_nxt;
`endif
    end
  end

  // Bus outputs are loaded on entry to a state so they are valid for that whole state.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    si_nxt    = si;
    sj_nxt    = sj;
    wait_nxt  = wait_cnt;
    addr_nxt  = addr_q;
    din_nxt   = din_q;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    key_load  = 1'b0;
    key_adv   = 1'b0;
`ifdef RC4_INIT_PHASE_EN
    init_nxt  = init_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          key_load = 1'b1;
          i_nxt    = '0;
          j_nxt    = '0;
          addr_nxt = '0;
`ifdef RC4_INIT_PHASE_EN
          state_nxt = INIT;
          init_nxt  = '0;
          din_nxt   = '0;
          we_nxt    = 1'b1;
`else
          state_nxt = ISSUE_I;
`endif
        end
      end
`ifdef RC4_INIT_PHASE_EN
      INIT: begin
        if (&init_cnt) begin
          state_nxt = ISSUE_I;
          addr_nxt  = i;
        end else begin
          init_nxt = ADDR_W'(init_cnt + 1'b1);
          addr_nxt = ADDR_W'(init_cnt + 1'b1);
          din_nxt  = DATA_W'(init_cnt + 1'b1);
          we_nxt   = 1'b1;
        end
      end
`endif
      ISSUE_I: begin
        state_nxt = WAIT_I;
        wait_nxt  = '0;
      end
      WAIT_I: begin
        if (wait_cnt == LAST_WAIT) begin
          si_nxt    = ram.ram_out;
          j_nxt     = j_sum;
          addr_nxt  = j_sum;
          state_nxt = ISSUE_J;
        end else begin
          wait_nxt = wait_cnt + 2'd1;
        end
      end
      ISSUE_J: begin
        state_nxt = WAIT_J;
        wait_nxt  = '0;
      end
      WAIT_J: begin
        if (wait_cnt == LAST_WAIT) begin
          sj_nxt    = ram.ram_out;
          addr_nxt  = i;
          din_nxt   = ram.ram_out;
          we_nxt    = 1'b1;
          state_nxt = WR_I;
        end else begin
          wait_nxt = wait_cnt + 2'd1;
        end
      end
      WR_I: begin
        addr_nxt  = j;
        din_nxt   = si;
        we_nxt    = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        if (&i) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          i_nxt     = ADDR_W'(i + 1'b1);
          addr_nxt  = ADDR_W'(i + 1'b1);
          key_adv   = 1'b1;
          state_nxt = ISSUE_I;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything; a write already on the bus completes at this edge.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      we_nxt    = 1'b0;
      done_nxt  = 1'b0;
      key_adv   = 1'b0;
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ksa_shuffler.sv
// Directed bench for ksa_shuffler: two instances (RD_LAT 1 and 3) on behavioural RAMs.
module tb_ksa_shuffler;

`ifdef RC4_INIT_PHASE_EN
  localparam int INIT_W = 256;
`else
  localparam int INIT_W = 0;
`endif
  localparam int ITER1 = 256 * 6;
  localparam int ITER3 = 256 * 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start1 = 1'b0, start3 = 1'b0, abort = 1'b0;
  logic [255:0] key = '0;
  logic [5:0]   key_len = 6'd1;
  logic         busy1, done1, busy3, done3;
  logic         preload = 1'b0, mon_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  ksa_shuffler_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();
  ksa_shuffler_if #(.DATA_W(8), .ADDR_W(8)) bus3 ();

  ksa_shuffler #(.DATA_W(8), .ADDR_W(8), .MAX_KEY_BYTES(32), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort), .key(key), .key_len(key_len),
    .busy(busy1), .done(done1), .ram(bus1));

  ksa_shuffler #(.DATA_W(8), .ADDR_W(8), .MAX_KEY_BYTES(32), .RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort), .key(key), .key_len(key_len),
    .busy(busy3), .done(done3), .ram(bus3));

  always #5 clk = ~clk;

  // RAM 1: one-cycle read, plus write/done monitors.
  logic [7:0] mem1 [256];
  logic [7:0] rd1, wa5, wa6, wd5, wd6;
  logic [7:0] snap [4];
  logic       snapped;
  int         cyc1 = 0, wc1 = 0, wcyc1a = 0, wcyc1b = 0, done_cnt1 = 0;

  always @(posedge clk) begin
    cyc1 <= cyc1 + 1;
    rd1  <= mem1[bus1.address];
    if (preload) for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
    else if (bus1.write_enable) mem1[bus1.address] <= bus1.ram_in;
    if (mon_clr) begin
      wc1 <= 0; snapped <= 1'b0; done_cnt1 <= 0;
    end else begin
      if (bus1.write_enable) begin
        wc1 <= wc1 + 1;
        if (wc1 == INIT_W)     wcyc1a <= cyc1;
        if (wc1 == INIT_W + 2) wcyc1b <= cyc1;
        if (wc1 == INIT_W + 4) begin wa5 <= bus1.address; wd5 <= bus1.ram_in; end
        if (wc1 == INIT_W + 5) begin wa6 <= bus1.address; wd6 <= bus1.ram_in; end
      end
      if (wc1 == INIT_W + 6 && !snapped) begin
        snapped <= 1'b1;
        for (int k = 0; k < 4; k++) snap[k] <= mem1[k];
      end
      if (done1) done_cnt1 <= done_cnt1 + 1;
    end
  end
  assign bus1.ram_out = rd1;

  // RAM 3: three-cycle read pipeline.
  logic [7:0] mem3 [256];
  logic [7:0] r3a, r3b, r3c;
  int         cyc3 = 0, wc3 = 0, wcyc3a = 0, wcyc3b = 0;

  always @(posedge clk) begin
    cyc3 <= cyc3 + 1;
    r3a  <= mem3[bus3.address];
    r3b  <= r3a;
    r3c  <= r3b;
    if (preload) for (int k = 0; k < 256; k++) mem3[k] <= 8'(k);
    else if (bus3.write_enable) mem3[bus3.address] <= bus3.ram_in;
    if (mon_clr) wc3 <= 0;
    else if (bus3.write_enable) begin
      wc3 <= wc3 + 1;
      if (wc3 == INIT_W)     wcyc3a <= cyc3;
      if (wc3 == INIT_W + 2) wcyc3b <= cyc3;
    end
  end
  assign bus3.ram_out = r3c;

  logic [7:0] exp_s [256];
  logic [7:0] save1 [256];

  // Software RC4 key schedule.
  function automatic void ksa_model(input logic [255:0] k, input int len);
    int jj;
    logic [7:0] kb, t;
    for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = k[(31 - (n % len)) * 8 +: 8];
      jj = (jj + int'(exp_s[n]) + int'(kb)) % 256;
      t = exp_s[n]; exp_s[n] = exp_s[jj]; exp_s[jj] = t;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ram1(input string tag);
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem1[k] !== exp_s[k]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic prep(input logic [255:0] k, input logic [5:0] len);
    key = k; key_len = len; preload = 1'b1; mon_clr = 1'b1;
    tick(1);
    preload = 1'b0; mon_clr = 1'b0;
  endtask

  // Full run on instance 1: done latency, single pulse, final RAM against the model.
  task automatic run1(input logic [255:0] k, input logic [5:0] len, input int model_len, input string tag);
    int n;
    prep(k, len);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    n = 0;
    while (!done1 && n < ITER1 + INIT_W + 50) begin tick(1); n++; end
    chk({tag, "_done_cyc"}, n, ITER1 + INIT_W);
    chk({tag, "_busy_at_done"}, busy1, 0);
    tick(1);
    chk({tag, "_done_pulses"}, done_cnt1, 1);
    ksa_model(k, model_len);
    chk_ram1({tag, "_ram"});
  endtask

  localparam logic [255:0] KEY_Z   = '0;
  localparam logic [255:0] KEY_123 = {8'h01, 8'h02, 8'h03, 232'h0};
  localparam logic [255:0] KEY_IJ  = {8'h00, 8'h00, 8'hFF, 232'h0};
  localparam logic [255:0] KEY_32  = 256'h0123456789abcdeffedcba9876543210_1f2e3d4c5b6a79880f1e2d3c4b5a6978;

  initial begin
    int n;
    int bad;

    // Reset state
    tick(3);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_addr", bus1.address, 0);
    chk("rst_din", bus1.ram_in, 0);
    chk("rst_we", bus1.write_enable, 0);
    chk("rst_busy3", busy3, 0);
    reset = 1'b0;
    tick(1);

    // Zero key, length 1: latency, snapshot after three iterations, iteration period
    run1(KEY_Z, 6'd1, 1, "k0");
    chk("k0_snap0", snap[0], 8'd0);
    chk("k0_snap1", snap[1], 8'd1);
    chk("k0_snap2", snap[2], 8'd3);
    chk("k0_snap3", snap[3], 8'd2);
    chk("k0_wa5", wa5, 8'd2);
    chk("k0_wa6", wa6, 8'd3);
    chk("k0_period", wcyc1b - wcyc1a, 6);
    for (int k = 0; k < 256; k++) save1[k] = mem1[k];

    // Same key on the RD_LAT=3 instance
    prep(KEY_Z, 6'd1);
    start3 = 1'b1; tick(1); start3 = 1'b0;
    n = 0;
    while (!done3 && n < ITER3 + INIT_W + 50) begin tick(1); n++; end
    chk("lat3_done_cyc", n, ITER3 + INIT_W);
    chk("lat3_period", wcyc3b - wcyc3a, 10);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem3[k] !== save1[k]) bad++;
    chk("lat3_ram_vs_lat1", bad, 0);
    tick(2);

    // Multi-byte key and zero-length key
    run1(KEY_123, 6'd3, 3, "k123");
    run1(KEY_32, 6'd0, 32, "klen0");
    run1(KEY_32, 6'd32, 32, "klen32");

    // Abort while WR_I of i=100 is on the bus
    prep(KEY_123, 6'd3);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    n = 0;
    while (!(bus1.write_enable && wc1 == INIT_W + 200) && n < 2000) begin tick(1); n++; end
    chk("abort_reach_cyc", n, INIT_W + 604);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_we", bus1.write_enable, 0);
    chk("abort_inflight", wc1, INIT_W + 201);
    tick(20);
    chk("abort_no_wr", wc1, INIT_W + 201);
    chk("abort_no_done", done_cnt1, 0);

    // Start while busy is ignored, then reset during WR_I of i=10
    prep(KEY_123, 6'd3);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    n = 0;
    while (!(bus1.write_enable && wc1 == INIT_W + 20) && n < 2000) begin
      tick(1); n++;
      start1 = (n == 3);
    end
    start1 = 1'b0;
    chk("busy_start_ignored", n, INIT_W + 64);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_addr", bus1.address, 0);
    chk("mid_rst_din", bus1.ram_in, 0);
    chk("mid_rst_we", bus1.write_enable, 0);
    chk("mid_rst_inflight", wc1, INIT_W + 21);
    tick(10);
    chk("mid_rst_no_wr", wc1, INIT_W + 21);
    run1(KEY_123, 6'd3, 3, "post_rst");

    // Key forcing j == i at i = 2
    run1(KEY_IJ, 6'd3, 3, "kij");
    chk("kij_snap2", snap[2], 8'd2);
    chk("kij_wa5", wa5, 8'd2);
    chk("kij_wa6", wa6, 8'd2);
    chk("kij_wd5", wd5, 8'd2);
    chk("kij_wd6", wd6, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
